// File: rtl/picobello_preload_arbiter.sv
// Locks the shared SoC preload/debug memory port to one requester per preload session,
// with boot-mode gating, in-order read tracking and end-of-computation snooping.
module picobello_preload_arbiter #(
    parameter int                   NumSrc      = 3,
    parameter int                   AddrWidth   = 48,
    parameter int                   DataWidth   = 64,
    parameter int                   MaxOutst    = 4,
    parameter int                   LockTimeout = 1024,
    parameter logic [AddrWidth-1:0] EocAddr     = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [1:0]                  boot_mode_i,
    input  logic [NumSrc-1:0]           src_req_i,
    input  logic [NumSrc-1:0]           src_we_i,
    input  logic [NumSrc*AddrWidth-1:0] src_addr_i,
    input  logic [NumSrc*DataWidth-1:0] src_wdata_i,
    output logic [NumSrc-1:0]           src_gnt_o,
    output logic [NumSrc-1:0]           src_rvalid_o,
    output logic [DataWidth-1:0]        src_rdata_o,
    output logic                        mst_req_o,
    output logic                        mst_we_o,
    output logic [AddrWidth-1:0]        mst_addr_o,
    output logic [DataWidth-1:0]        mst_wdata_o,
    input  logic                        mst_gnt_i,
    input  logic                        mst_rvalid_i,
    input  logic [DataWidth-1:0]        mst_rdata_i,
    output logic [$clog2(NumSrc)-1:0]   owner_o,
    output logic                        locked_o,
    output logic                        eoc_valid_o,
    output logic [31:0]                 exit_code_o
);
    localparam int IdxW  = $clog2(NumSrc);
    localparam int OutW  = $clog2(MaxOutst + 1);
    localparam int IdleW = $clog2(LockTimeout + 1);

    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        owner_q, rr_q, winner, cand;
    logic [OutW-1:0]        outst_q;
    logic [IdleW-1:0]       idle_q, idle_d;
    logic                   eoc_vld_p1;
    logic [31:0]            exit_code_p1;
    logic [NumSrc-1:0]      eligible;
    logic                   found, owned, own_req, own_we, own_pass, full, grant, rsp_ok;
    logic [AddrWidth-1:0]   own_addr;
    logic [DataWidth-1:0]   own_wdata;

    // Outside idle/preload boot mode only the JTAG bridge may touch memory, and read-only.
    function automatic logic src_pass(input logic [IdxW-1:0] idx, input logic we,
                                      input logic [1:0] mode);
        return (mode == 2'd0) || ((idx == '0) && !we);
    endfunction

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumSrc; i++) begin
            eligible[i] = src_req_i[i] && src_pass(IdxW'(i), src_we_i[i], boot_mode_i);
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NumSrc; k++) begin
            cand = IdxW'((int'(rr_q) + k) % NumSrc);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (owner_q == IdxW'(i)) begin
                own_req   = src_req_i[i];
                own_we    = src_we_i[i];
                own_addr  = src_addr_i[i*AddrWidth +: AddrWidth];
                own_wdata = src_wdata_i[i*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        owned    = (state_q == OWNED);
        own_pass = src_pass(owner_q, own_req && own_we, boot_mode_i);
        full     = (outst_q == OutW'(MaxOutst));

        mst_req_o   = owned && own_req && own_pass && (own_we || !full);
        mst_we_o    = owned ? own_we : 1'b0;
        mst_addr_o  = owned ? own_addr : '0;
        mst_wdata_o = owned ? own_wdata : '0;
        grant       = mst_req_o && mst_gnt_i;

        // Responses with nothing outstanding are stray (e.g. issued before a reset).
        rsp_ok       = mst_rvalid_i && (outst_q != '0);
        src_gnt_o    = '0;
        src_rvalid_o = '0;
        src_gnt_o[owner_q]    = grant;
        src_rvalid_o[owner_q] = rsp_ok;
        src_rdata_o  = rsp_ok ? mst_rdata_i : '0;

        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (found) state_d = OWNED;
            end
            OWNED: begin
                idle_d = own_req ? '0 : idle_q + 1'b1;
                if (!own_pass || idle_d == IdleW'(LockTimeout)) state_d = DRAIN;
            end
            DRAIN: begin
                if (outst_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_q         <= '0;
            outst_q      <= '0;
            idle_q       <= '0;
            eoc_vld_p1   <= 1'b0;
            exit_code_p1 <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            if (state_q == IDLE && found) owner_q <= winner;
            if (state_q == DRAIN && outst_q == '0) begin
                rr_q <= (owner_q == IdxW'(NumSrc - 1)) ? '0 : owner_q + 1'b1;
            end
            case ({grant && !mst_we_o, rsp_ok})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
            // EOC snoop stage: granted scratch write with the done bit set
            if (grant && mst_we_o && mst_addr_o == EocAddr && mst_wdata_o[0]) begin
                eoc_vld_p1   <= 1'b1;
                exit_code_p1 <= {1'b0, mst_wdata_o[31:1]};
            end
        end
    end

    assign owner_o     = owner_q;
    assign locked_o    = (state_q != IDLE);
    assign eoc_valid_o = eoc_vld_p1;
    assign exit_code_o = exit_code_p1;
endmodule

// File: tb/tb_picobello_preload_arbiter.sv
// Scenario bench for the preload arbiter: directed sessions plus a randomized read stream
// scored against an outstanding-count model.
module tb_picobello_preload_arbiter;
    localparam int        NS  = 3;
    localparam int        AW  = 48;
    localparam int        DW  = 64;
    localparam int        MO  = 4;
    localparam int        LT  = 16;
    localparam logic [47:0] EOC = 48'h40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        boot_mode;
    logic [NS-1:0]     src_req, src_we, src_gnt, src_rvalid;
    logic [NS*AW-1:0]  src_addr;
    logic [NS*DW-1:0]  src_wdata;
    logic [DW-1:0]     src_rdata, mst_wdata, mst_rdata;
    logic              mst_req, mst_we, mst_gnt, mst_rvalid, locked, eoc_valid;
    logic [AW-1:0]     mst_addr;
    logic [1:0]        owner;
    logic [31:0]       exit_code;
    int                checks = 0;
    int                errors = 0;

    picobello_preload_arbiter #(
        .NumSrc(NS), .AddrWidth(AW), .DataWidth(DW), .MaxOutst(MO),
        .LockTimeout(LT), .EocAddr(EOC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .boot_mode_i(boot_mode),
        .src_req_i(src_req), .src_we_i(src_we), .src_addr_i(src_addr),
        .src_wdata_i(src_wdata), .src_gnt_o(src_gnt), .src_rvalid_o(src_rvalid),
        .src_rdata_o(src_rdata), .mst_req_o(mst_req), .mst_we_o(mst_we),
        .mst_addr_o(mst_addr), .mst_wdata_o(mst_wdata), .mst_gnt_i(mst_gnt),
        .mst_rvalid_i(mst_rvalid), .mst_rdata_i(mst_rdata), .owner_o(owner),
        .locked_o(locked), .eoc_valid_o(eoc_valid), .exit_code_o(exit_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src();
        src_req = '0; src_we = '0; src_addr = '0; src_wdata = '0;
        mst_gnt = 1'b0; mst_rvalid = 1'b0; mst_rdata = '0;
    endtask

    task automatic set_src(input int s, input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_req[s] = req;
        src_we[s]  = we;
        src_addr[s*AW +: AW] = a;
        src_wdata[s*DW +: DW] = d;
    endtask

    task automatic do_reset();
        clear_src();
        boot_mode = 2'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_src();
        boot_mode = 2'd0;
        rst = 1'b1;
        src_req = 3'b111; mst_gnt = 1'b1; mst_rvalid = 1'b1;
        mst_rdata = {$urandom(), $urandom()};
        #1;
        checks++;
        if ({src_gnt, src_rvalid, mst_req, mst_we, locked, eoc_valid} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {src_gnt, src_rvalid, mst_req, mst_we, locked, eoc_valid});
        end
        checks++;
        if (src_rdata !== '0 || mst_addr !== '0 || mst_wdata !== '0) begin
            errors++;
            $display("FAIL reset_data got rdata %h addr %h wdata %h want 0", src_rdata, mst_addr, mst_wdata);
        end
        checks++;
        if (owner !== 2'd0 || exit_code !== 32'd0) begin
            errors++;
            $display("FAIL reset_owner_exit got owner %0d exit %0d want 0 0", owner, exit_code);
        end
        step();
        rst = 1'b0;
        mst_rvalid = 1'b0;
        #1;
        checks++;
        if (src_gnt !== 3'b000) begin
            errors++;
            $display("FAIL reset_arb_latency got %b want 000", src_gnt);
        end
        step();
        checks++;
        if (owner !== 2'd0 || locked !== 1'b1 || src_gnt !== 3'b001) begin
            errors++;
            $display("FAIL reset_rr_start got owner %0d locked %b gnt %b want 0 1 001", owner, locked, src_gnt);
        end
    endtask

    task automatic test_rr_lock();
        int got;
        do_reset();
        set_src(1, 1'b1, 1'b1, 48'h1000, {$urandom(), $urandom()});
        set_src(2, 1'b1, 1'b1, 48'h2000, 64'h55);
        mst_gnt = 1'b1;
        #1;
        checks++;
        if (src_gnt !== 3'b000) begin
            errors++;
            $display("FAIL rr_idle_cycle got %b want 000", src_gnt);
        end
        step();
        checks++;
        if (owner !== 2'd1 || locked !== 1'b1 || src_gnt !== 3'b010) begin
            errors++;
            $display("FAIL rr_first_owner got owner %0d locked %b gnt %b want 1 1 010", owner, locked, src_gnt);
        end
        checks++;
        if (mst_addr !== 48'h1000 || mst_we !== 1'b1) begin
            errors++;
            $display("FAIL rr_mux got addr %h we %b want 1000 1", mst_addr, mst_we);
        end
        step();
        src_req[1] = 1'b0;
        got = -1;
        for (int c = 0; c < LT + 10 && got < 0; c++) begin
            #1;
            if (src_gnt[2]) got = c;
            else step();
        end
        // idle LT cycles, one drain cycle, one arbitration cycle
        checks++;
        if (got !== LT + 2) begin
            errors++;
            $display("FAIL rr_handover got cycle %0d want %0d", got, LT + 2);
        end
        checks++;
        if (owner !== 2'd2 || mst_addr !== 48'h2000 || mst_wdata !== 64'h55) begin
            errors++;
            $display("FAIL rr_second_owner got owner %0d addr %h wdata %h want 2 2000 55", owner, mst_addr, mst_wdata);
        end
    endtask

    task automatic test_outstanding();
        logic [DW-1:0] d;
        do_reset();
        set_src(0, 1'b1, 1'b0, 48'h300, '0);
        mst_gnt = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (src_gnt[0] !== (k < MO)) begin
                errors++;
                $display("FAIL outst_read%0d got gnt %b want %b", k, src_gnt[0], (k < MO));
            end
            step();
        end
        d = {$urandom(), $urandom()};
        mst_rvalid = 1'b1; mst_rdata = d;
        #1;
        checks++;
        if (src_rvalid !== 3'b001 || src_rdata !== d || src_gnt !== 3'b000) begin
            errors++;
            $display("FAIL outst_rsp got rv %b data %h gnt %b want 001 %h 000", src_rvalid, src_rdata, src_gnt, d);
        end
        step();
        mst_rvalid = 1'b0;
        #1;
        checks++;
        if (src_gnt !== 3'b001) begin
            errors++;
            $display("FAIL outst_fifth got gnt %b want 001", src_gnt);
        end
    endtask

    task automatic test_random_reads();
        int own, cnt;
        logic req, gnt, rv, exp_req;
        logic [2:0] exp_gnt, exp_rv;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        do_reset();
        own = int'($urandom_range(0, 2));
        set_src(own, 1'b1, 1'b0, '0, '0);
        step();
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            req = ($urandom_range(0, 3) != 0);
            gnt = ($urandom_range(0, 1) != 0);
            rv  = ($urandom_range(0, 1) != 0);
            a   = AW'({$urandom(), $urandom()});
            d   = {$urandom(), $urandom()};
            set_src(own, req, 1'b0, a, '0);
            mst_gnt = gnt; mst_rvalid = rv; mst_rdata = d;
            #1;
            exp_req = req && (cnt < MO);
            exp_gnt = (exp_req && gnt) ? 3'(1 << own) : 3'b000;
            exp_rv  = (rv && cnt > 0) ? 3'(1 << own) : 3'b000;
            checks++;
            if (mst_req !== exp_req || src_gnt !== exp_gnt) begin
                errors++;
                $display("FAIL rand_req c%0d got req %b gnt %b want %b %b", c, mst_req, src_gnt, exp_req, exp_gnt);
            end
            checks++;
            if (src_rvalid !== exp_rv || (exp_rv != 3'b000 && src_rdata !== d)) begin
                errors++;
                $display("FAIL rand_rsp c%0d got rv %b data %h want %b %h", c, src_rvalid, src_rdata, exp_rv, d);
            end
            checks++;
            if (locked !== 1'b1 || owner !== own[1:0] || (req && mst_addr !== a)) begin
                errors++;
                $display("FAIL rand_owner c%0d got owner %0d locked %b addr %h want %0d 1 %h", c, owner, locked, mst_addr, own, a);
            end
            cnt = cnt + ((exp_req && gnt) ? 1 : 0) - ((rv && cnt > 0) ? 1 : 0);
            step();
        end
    endtask

    task automatic test_gating();
        do_reset();
        boot_mode = 2'd2;
        set_src(1, 1'b1, 1'b1, 48'h500, 64'h1);
        set_src(0, 1'b1, 1'b0, 48'h600, '0);
        mst_gnt = 1'b1;
        #1;
        checks++;
        if (src_gnt !== 3'b000) begin
            errors++;
            $display("FAIL gate_idle got %b want 000", src_gnt);
        end
        step();
        checks++;
        if (owner !== 2'd0 || src_gnt !== 3'b001) begin
            errors++;
            $display("FAIL gate_owner got owner %0d gnt %b want 0 001", owner, src_gnt);
        end
        step();
        mst_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (src_gnt !== 3'b001 || src_rvalid !== 3'b001) begin
                errors++;
                $display("FAIL gate_stream%0d got gnt %b rv %b want 001 001", k, src_gnt, src_rvalid);
            end
            step();
        end
        mst_rvalid = 1'b0;
        src_we[0] = 1'b1;
        #1;
        checks++;
        if (mst_req !== 1'b0 || src_gnt !== 3'b000) begin
            errors++;
            $display("FAIL gate_write_blocked got req %b gnt %b want 0 000", mst_req, src_gnt);
        end
        step();
        mst_rvalid = 1'b1;
        #1;
        checks++;
        if (src_rvalid !== 3'b001) begin
            errors++;
            $display("FAIL gate_drain_rsp got %b want 001", src_rvalid);
        end
        step();
        mst_rvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (src_gnt !== 3'b000 || mst_req !== 1'b0) begin
                errors++;
                $display("FAIL gate_stall%0d got gnt %b req %b want 000 0", k, src_gnt, mst_req);
            end
            step();
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL gate_unlocked got %b want 0", locked);
        end
    endtask

    task automatic test_eoc();
        logic [DW-1:0] w;
        logic [31:0] exp_code;
        do_reset();
        set_src(1, 1'b1, 1'b1, EOC, 64'h6);
        mst_gnt = 1'b1;
        step();
        checks++;
        if (src_gnt !== 3'b010) begin
            errors++;
            $display("FAIL eoc_owner got gnt %b want 010", src_gnt);
        end
        step();
        checks++;
        if (eoc_valid !== 1'b0) begin
            errors++;
            $display("FAIL eoc_even_ignored got %b want 0", eoc_valid);
        end
        src_wdata[1*DW +: DW] = 64'h7;
        #1;
        checks++;
        if (eoc_valid !== 1'b0) begin
            errors++;
            $display("FAIL eoc_same_cycle got %b want 0", eoc_valid);
        end
        step();
        checks++;
        if (eoc_valid !== 1'b1 || exit_code !== 32'd3) begin
            errors++;
            $display("FAIL eoc_seven got valid %b code %0d want 1 3", eoc_valid, exit_code);
        end
        w = {$urandom(), $urandom()} | 64'h1;
        set_src(1, 1'b1, 1'b1, 48'h80, w);
        step();
        w = {$urandom(), $urandom()} | 64'h1;
        set_src(1, 1'b1, 1'b1, EOC, w);
        mst_gnt = 1'b0;
        step();
        checks++;
        if (exit_code !== 32'd3) begin
            errors++;
            $display("FAIL eoc_not_taken got %0d want 3", exit_code);
        end
        mst_gnt = 1'b1;
        step();
        exp_code = {1'b0, w[31:1]};
        checks++;
        if (exit_code !== exp_code) begin
            errors++;
            $display("FAIL eoc_overwrite got %h want %h", exit_code, exp_code);
        end
        src_wdata[1*DW +: DW] = w & ~64'h1;
        step();
        checks++;
        if (exit_code !== exp_code || eoc_valid !== 1'b1) begin
            errors++;
            $display("FAIL eoc_sticky got %h %b want %h 1", exit_code, eoc_valid, exp_code);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_src(2, 1'b1, 1'b0, 48'h900, '0);
        mst_gnt = 1'b1;
        step();
        step();
        step();
        src_req = '0;
        mst_gnt = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({src_gnt, src_rvalid, mst_req, locked, eoc_valid} !== 9'd0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL midrst_outputs got %b owner %0d want 0 0", {src_gnt, src_rvalid, mst_req, locked, eoc_valid}, owner);
        end
        #1 rst = 1'b0;
        mst_rvalid = 1'b1;
        mst_rdata = {$urandom(), $urandom()};
        #1;
        checks++;
        if (src_rvalid !== 3'b000 || src_rdata !== '0) begin
            errors++;
            $display("FAIL midrst_late_rsp got rv %b data %h want 000 0", src_rvalid, src_rdata);
        end
        step();
        checks++;
        if (src_rvalid !== 3'b000 || locked !== 1'b0) begin
            errors++;
            $display("FAIL midrst_late_rsp2 got rv %b locked %b want 000 0", src_rvalid, locked);
        end
        mst_rvalid = 1'b0;
        set_src(1, 1'b1, 1'b0, 48'h10, '0);
        mst_gnt = 1'b1;
        step();
        checks++;
        if (owner !== 2'd1 || src_gnt !== 3'b010) begin
            errors++;
            $display("FAIL midrst_rearb got owner %0d gnt %b want 1 010", owner, src_gnt);
        end
    endtask

    initial begin
        clear_src();
        boot_mode = 2'd0;
        test_reset();
        test_rr_lock();
        test_outstanding();
        test_random_reads();
        test_gating();
        test_eoc();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
